// File: rtl/BrLitePkg.sv
// Shared BrLite types: router flit word and the local-port arbiter state encoding.
package BrLitePkg;

    typedef logic [31:0] br_data_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_SEND = 2'd1,
        ARB_DONE = 2'd2,
        ARB_GAP  = 2'd3
    } br_arb_state_t;

    // Gap counter width; a zero gap still keeps a 1-bit counter.
    function automatic int br_cnt_width(input int gap);
        return (gap > 0) ? $clog2(gap + 1) : 1;
    endfunction

endpackage

// File: rtl/br_rr_picker.sv
// Combinational round-robin priority encoder: search upward from last+1 (mod N),
// return the first active request as one-hot and as an index.
module br_rr_picker #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          vld
);

    logic          found;
    logic [IW-1:0] cand;
    int            cand_i;

    always_comb begin
        gnt    = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        cand_i = 0;
        for (int i = 1; i <= N; i++) begin
            cand_i = (int'(last) + i) % N;
            cand   = IW'(cand_i);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

    assign vld = |req;

endmodule

// File: rtl/br_local_arbiter.sv
// Shares the router local injection port among N_REQ requesters: round-robin grant,
// registered flit, router req/ack handshake, then an optional idle gap.
module br_local_arbiter
    import BrLitePkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [N_REQ-1:0]      req_i,
    input  br_data_t [N_REQ-1:0]  flit_i,
    output logic [N_REQ-1:0]      ack_o,
    output logic [N_REQ-1:0]      grant_o,
    input  logic                  busy_i,
    output br_data_t              flit_o,
    output logic                  req_o,
    input  logic                  ack_i,
    output logic                  busy_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = br_cnt_width(GAP_CYCLES);
    localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    br_arb_state_t    state_q, state_d;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    last_q;
    logic             pick_vld;
    logic [CW-1:0]    cnt_q;
    br_data_t         flit_q;
    logic             take;

    br_rr_picker #(.N(N_REQ), .IW(IW)) u_picker (
        .req  (req_i),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    assign take = (state_q == ARB_IDLE) && en_i && !busy_i && pick_vld;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ARB_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (take)  state_d = ARB_SEND;
            ARB_SEND: if (ack_i) state_d = ARB_DONE;
            ARB_DONE: state_d = (GAP_CYCLES == 0) ? ARB_IDLE : ARB_GAP;
            ARB_GAP:  if (cnt_q == '0) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // The flit is captured at grant so requester-side changes during SEND never reach the router.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flit_q  <= '0;
            grant_q <= '0;
            last_q  <= IW'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            if (take) begin
                flit_q  <= flit_i[pick_idx];
                grant_q <= pick_gnt;
                last_q  <= pick_idx;
            end
            if (state_q == ARB_DONE) begin
                grant_q <= '0;
                cnt_q   <= GAP_LOAD;
            end else if (state_q == ARB_GAP && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign flit_o  = flit_q;
    assign req_o   = (state_q == ARB_SEND);
    assign ack_o   = (state_q == ARB_DONE) ? grant_q : '0;
    assign grant_o = grant_q;
    assign busy_o  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_br_local_arbiter.sv
// Directed bench: one arbiter with no gap, one with a 4-cycle gap, driven from shared requesters.
module tb_br_local_arbiter;
    import BrLitePkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            busy;
    logic            ack0;
    logic            ack4;
    logic [2:0]      req;
    br_data_t [2:0]  flit;

    logic [2:0] ack_o0, grant0, ack_o4, grant4;
    br_data_t   flit_o0, flit_o4;
    logic       req_o0, busy_o0, req_o4, busy_o4;

    int n_vec = 0;
    int n_err = 0;
    int acks [3];
    logic [2:0] oh;

    always #5 clk = ~clk;

    br_local_arbiter #(.N_REQ(3), .GAP_CYCLES(0)) u_g0 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req), .flit_i(flit),
        .ack_o(ack_o0), .grant_o(grant0), .busy_i(busy), .flit_o(flit_o0),
        .req_o(req_o0), .ack_i(ack0), .busy_o(busy_o0)
    );

    br_local_arbiter #(.N_REQ(3), .GAP_CYCLES(4)) u_g4 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req), .flit_i(flit),
        .ack_o(ack_o4), .grant_o(grant4), .busy_i(busy), .flit_o(flit_o4),
        .req_o(req_o4), .ack_i(ack4), .busy_o(busy_o4)
    );

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        busy = 1'b0;
        ack0 = 1'b0;
        ack4 = 1'b0;
        req  = '0;
        flit = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        expect_eq("rst_grant0", grant0, 3'b000);
        expect_eq("rst_busy0", busy_o0, 1'b0);
        expect_eq("rst_req0", req_o0, 1'b0);
        expect_eq("rst_flit0", flit_o0, 32'h0);
        expect_eq("rst_ack0", ack_o0, 3'b000);
        expect_eq("rst_busy4", busy_o4, 1'b0);

        // Single requester, ack tied high: 3-cycle injection period.
        en = 1'b1; ack0 = 1'b1; req = 3'b010; flit[1] = 32'h2A;
        tick();
        expect_eq("s_req", req_o0, 1'b1);
        expect_eq("s_flit", flit_o0, 32'h2A);
        expect_eq("s_grant", grant0, 3'b010);
        expect_eq("s_noack", ack_o0, 3'b000);
        expect_eq("s_busy", busy_o0, 1'b1);
        flit[1] = 32'h2B;
        tick();
        expect_eq("s_done_req", req_o0, 1'b0);
        expect_eq("s_done_ack", ack_o0, 3'b010);
        expect_eq("s_done_grant", grant0, 3'b010);
        tick();
        expect_eq("s_idle_busy", busy_o0, 1'b0);
        expect_eq("s_idle_ack", ack_o0, 3'b000);
        expect_eq("s_idle_grant", grant0, 3'b000);
        tick();
        expect_eq("s_period_req", req_o0, 1'b1);
        expect_eq("s_period_flit", flit_o0, 32'h2B);

        // Asynchronous reset while SEND is active.
        req = '0;
        #3 rst = 1'b1;
        #1;
        expect_eq("mid_rst_req", req_o0, 1'b0);
        expect_eq("mid_rst_ack", ack_o0, 3'b000);
        expect_eq("mid_rst_grant", grant0, 3'b000);
        expect_eq("mid_rst_flit", flit_o0, 32'h0);
        expect_eq("mid_rst_busy", busy_o0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        expect_eq("post_rst_grant", grant0, 3'b000);
        expect_eq("post_rst_busy", busy_o0, 1'b0);

        // Round-robin with all three requesting.
        req = 3'b111; flit[0] = 32'hA0; flit[1] = 32'hA1; flit[2] = 32'hA2;
        for (int j = 0; j < 3; j++) acks[j] = 0;
        for (int t = 0; t < 6; t++) begin
            oh = 3'b001 << (t % 3);
            tick();
            expect_eq("rr_grant", grant0, oh);
            expect_eq("rr_flit", flit_o0, 32'hA0 + (t % 3));
            tick();
            expect_eq("rr_ack", ack_o0, oh);
            for (int j = 0; j < 3; j++) if (ack_o0[j]) acks[j]++;
            tick();
        end
        for (int j = 0; j < 3; j++) expect_eq("rr_count", acks[j], 2);

        // Busy / enable hold-off, and busy ignored during SEND.
        req = 3'b001; ack0 = 1'b0; busy = 1'b1;
        tick();
        expect_eq("hold_busy", grant0, 3'b000);
        busy = 1'b0; en = 1'b0;
        tick();
        expect_eq("hold_en", grant0, 3'b000);
        en = 1'b1;
        tick();
        expect_eq("release_grant", grant0, 3'b001);
        expect_eq("release_req", req_o0, 1'b1);
        busy = 1'b1; en = 1'b0;
        tick();
        expect_eq("send_busy_req", req_o0, 1'b1);
        expect_eq("send_busy_grant", grant0, 3'b001);
        ack0 = 1'b1;
        tick();
        expect_eq("send_busy_ack", ack_o0, 3'b001);
        req = '0; busy = 1'b0; en = 1'b1;
        tick();

        // Stale request from 1 after its ack must not win over waiting requester 2.
        req = 3'b110; flit[1] = 32'hB1; flit[2] = 32'hB2;
        tick();
        expect_eq("stale_g1", grant0, 3'b010);
        tick();
        expect_eq("stale_ack1", ack_o0, 3'b010);
        tick();
        expect_eq("stale_idle", grant0, 3'b000);
        tick();
        expect_eq("stale_g2", grant0, 3'b100);
        expect_eq("stale_flit2", flit_o0, 32'hB2);
        req = 3'b100;
        tick();
        expect_eq("stale_ack2", ack_o0, 3'b100);
        req = 3'b000;
        tick();
        tick();
        expect_eq("stale_no_regrant", grant0, 3'b000);

        // Gap of 4 with a 5-cycle delayed router ack.
        pulse_reset();
        req = 3'b001; flit[0] = 32'h55; ack4 = 1'b0;
        tick();
        expect_eq("gap_req_first", req_o4, 1'b1);
        expect_eq("gap_flit_first", flit_o4, 32'h55);
        flit[0] = 32'h66;
        for (int i = 1; i <= 5; i++) begin
            tick();
            expect_eq("gap_req_held", req_o4, 1'b1);
            expect_eq("gap_flit_stable", flit_o4, 32'h55);
        end
        ack4 = 1'b1;
        tick();
        expect_eq("gap_done_req", req_o4, 1'b0);
        expect_eq("gap_done_ack", ack_o4, 3'b001);
        ack4 = 1'b0; flit[0] = 32'h77;
        for (int j = 1; j <= 5; j++) begin
            tick();
            expect_eq("gap_quiet_req", req_o4, 1'b0);
            expect_eq("gap_quiet_grant", grant4, 3'b000);
            expect_eq("gap_busy", busy_o4, (j < 5) ? 1'b1 : 1'b0);
        end
        tick();
        expect_eq("gap_next_req", req_o4, 1'b1);
        expect_eq("gap_next_flit", flit_o4, 32'h77);
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/br_local_arbiter.md
# br_local_arbiter

Round-robin scheduler that shares one BrLite router's local injection port between `N_REQ` on-tile requesters, such as the kernel, a DMA engine and a monitor. It sits between the requesters and the router's `BR_LOCAL` input (`flit_i`/`req_i`/`ack_o`). It grants one requester at a time and drives the router handshake. It also enforces a minimum idle gap between injections and holds off while the router reports its local port busy.

## Interface
- `N_REQ`, default 3: number of requesters, ≥ 2.
- `GAP_CYCLES`, default 0: idle cycles inserted after each completed injection, ≥ 0.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `en_i`  in  1  arbitration enable; low blocks new grants only.
- `req_i`  in  `N_REQ`  per-requester request.
- `flit_i`  in  `br_data_t [N_REQ-1:0]`  per-requester flit, stable while `req_i[k]` is high.
- `ack_o`  out  `N_REQ`  one-cycle completion pulse to the granted requester.
- `grant_o`  out  `N_REQ`  one-hot current owner, zero when idle.
- `busy_i`  in  1  router local busy.
- `flit_o`  out  `br_data_t`  to router local `flit_i`.
- `req_o`  out  1  to router local `req_i`.
- `ack_i`  in  1  from router local `ack_o`.
- `busy_o`  out  1  high whenever the state is not IDLE.

## Operation
FSM states: IDLE, SEND, DONE, GAP.
- **IDLE**
  - Grant condition: `en_i && !busy_i && |req_i`.
  - When the condition holds, pick the winner k round-robin: search from `last+1` mod `N_REQ` upward.
  - On the grant: register `flit_i[k]` into `flit_o`, set `grant_o = 1<<k`, set `last = k`, and go to SEND.
  - When the condition fails, stay in IDLE.
- **SEND**
  - `req_o = 1`.
  - `flit_o` holds the registered value; later changes on `flit_i[k]` are ignored.
  - On `ack_i = 1`, go to DONE.
  - `en_i` and `busy_i` are ignored once SEND has been entered.
- **DONE** (exactly one cycle)
  - `req_o = 0`, `ack_o[k] = 1`, `grant_o` still shows k.
  - Next state is GAP with the counter loaded to `GAP_CYCLES-1`, or IDLE if `GAP_CYCLES = 0`.
- **GAP**
  - Counter decrements each cycle; at zero, go to IDLE.
  - `grant_o = 0`.
  - Counter width is `$clog2(GAP_CYCLES+1)`, minimum 1.

Requester contract:
- Hold `req_i[k]` high with a stable flit until `ack_o[k]`.
- In the cycle after `ack_o[k]`, either drop `req_i[k]` or present a new flit with `req_i[k]` still high.
- `req_i` is never sampled in DONE, so a stale request is never regranted.

Arbitration details:
- `last` resets to `N_REQ-1`, so requester 0 wins first.
- A lone requester can be granted back-to-back.
- Dropping `req_i` while not granted is legal.
- Dropping `req_i` while granted is a protocol error: the registered flit is still sent.

Reset:
- Asynchronous; effective immediately, even mid-SEND.
- State IDLE, `req_o = 0`, `flit_o = '0`, `ack_o = 0`, `grant_o = 0`, `busy_o = 0`, gap counter 0, `last = N_REQ-1`.
- An in-flight flit is dropped with no `ack_o`; the requester re-requests after reset.

## Timing
- All outputs are registered from FSM state and datapath registers. There are no combinational paths from `req_i`, `ack_i` or `busy_i` to outputs.
- Request sampled in IDLE at edge C gives `req_o` high in cycle C+1.
- Handshake completes at the edge where `req_o && ack_i`. `req_o` is low and `ack_o[k]` is high in the following cycle.
- Minimum injection period with an immediate `ack_i`: 3 + `GAP_CYCLES` cycles (grant, SEND, DONE, gap, IDLE→grant).
- `ack_i` held high across multiple cycles counts as a single transfer, because SEND is left on the first one.
- `busy_i` rising in the same cycle as a grant decision blocks that grant.

## Structure
- In `BrLitePkg`:
  - state enum `br_arb_state_t`.
  - reuse of the existing `br_data_t`.
- One sub-module: `br_rr_picker`. It is a combinational round-robin priority encoder: `req`, `last` → one-hot `gnt` and index. It is reusable by other BrLite arbiters.
- The FSM, flit register and gap counter live in `br_local_arbiter`.

## Test plan
- **Reset defaults:** assert `rst_i` mid-SEND (`req_o = 1`) → outputs zero in the same cycle, no `ack_o`. After release, `grant_o = 0` and `busy_o = 0`.
- **Single requester:** `req_i = 3'b010`, flit `0x2A`, `ack_i` tied high, `GAP_CYCLES = 0`.
  - Expect `req_o` at C+1 with `flit_o = 0x2A`, `ack_o = 3'b010` at C+2.
  - Expect period 3 cycles for repeated flits.
- **Round-robin fairness:** `req_i = 3'b111` held, N=3 → grant order 0,1,2,0,1,2; each receives exactly 2 `ack_o` pulses in 6 transfers.
- **Gap and back-pressure:** `GAP_CYCLES = 4`, `ack_i` delayed 5 cycles.
  - Expect `req_o` held 6 cycles with `flit_o` stable.
  - Expect the next `req_o` exactly 6 cycles after `ack_o`.
- **Busy/enable hold-off:** `busy_i = 1` or `en_i = 0` with `req_i = 3'b001` → no grant. Clearing both grants on the next edge. Raising `busy_i` during SEND does not abort.
- **Stale request:** requester 1 keeps `req_i` high one cycle after `ack_o` with unchanged flit, then drops; requester 2 is waiting → next grant goes to 2, and requester 1 is not regranted.
